// File: rtl/ring_mem_requester_pkg.sv
// Shared ring definitions: slot-type macros, address-word field positions, requester FSM states.
// Address word layout: [28] = read flag, [25:0] = line address, all other bits zero.
`ifndef RING_DEFS_SV
`define RING_DEFS_SV
`define Null      4'd0
`define Token     4'd1
`define Address   4'd2
`define WriteData 4'd3
`endif

package ring_mem_requester_pkg;

    localparam logic [3:0] SLOT_NULL      = `Null;
    localparam logic [3:0] SLOT_TOKEN     = `Token;
    localparam logic [3:0] SLOT_ADDRESS   = `Address;
    localparam logic [3:0] SLOT_WRITEDATA = `WriteData;

    localparam int READ_BIT = 28;
    localparam int ADDR_MSB = 25;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_TOKEN = 3'd1,
        SEND_WD    = 3'd2,
        RELEASE    = 3'd3,
        WAIT_RD    = 3'd4
    } reqState_t;

    function automatic logic [31:0] addrWord(input logic isWrite, input logic [ADDR_MSB:0] addr);
        logic [31:0] w;
        w              = '0;
        w[READ_BIT]    = ~isWrite;
        w[ADDR_MSB:0]  = addr;
        return w;
    endfunction

endpackage

// File: rtl/ring_line_assembler.sv
// Collects four 32-bit words addressed to MY_ID into one 128-bit line (word0 = [31:0]).
// Latency: done pulses the cycle after the fourth word is captured; line holds until the next done.
// Backpressure: none; words are taken whenever enable is high and dest matches, clear wins over capture.
module ring_line_assembler #(
    parameter logic [3:0] MY_ID = 4'd1
) (
    input  logic         clock,
    input  logic         resetB,
    input  logic         clear,
    input  logic         enable,
    input  logic [3:0]   dest,
    input  logic [31:0]  word,
    output logic         lastWord,
    output logic         done,
    output logic [127:0] line
);

    logic [1:0]  rcnt;
    logic [95:0] partial;
    logic        capture;

    assign capture  = enable && (dest == MY_ID) && !clear;
    assign lastWord = capture && (rcnt == 2'd3);

    always_ff @(posedge clock) begin
        if (!resetB) begin
            rcnt    <= 2'd0;
            partial <= '0;
            done    <= 1'b0;
            line    <= '0;
        end else begin
            done <= lastWord;
            if (clear) begin
                rcnt <= 2'd0;
            end else if (capture) begin
                rcnt <= rcnt + 2'd1;
                case (rcnt)
                    2'd0:    partial[31:0]  <= word;
                    2'd1:    partial[63:32] <= word;
                    2'd2:    partial[95:64] <= word;
                    default: line           <= {word, partial};
                endcase
            end
        end
    end

endmodule

// File: rtl/ring_mem_requester.sv
// Ring node feeding the memory mux: injects Address (+4 WriteData) on token, then re-issues token; assembles read lines.
// Latency: write token-in to token-out 5 cycles, read 1 cycle; rspValid one cycle after release / last read word.
// Backpressure: one request outstanding, reqReady low from accept until the cycle after rspValid. Option: RD_TIMEOUT_EN.
module ring_mem_requester
    import ring_mem_requester_pkg::*;
#(
    parameter logic [3:0] MY_ID   = 4'd1,
    parameter int         TIMEOUT = 1023
) (
    input  logic           clock,
    input  logic           resetB,
    input  logic [31:0]    RingIn,
    input  logic [3:0]     SlotTypeIn,
    input  logic [3:0]     SourceIn,
    output logic [31:0]    RingOut,
    output logic [3:0]     SlotTypeOut,
    output logic [3:0]     SourceOut,
    input  logic [31:0]    RDreturn,
    input  logic [3:0]     RDdest,
    input  logic           reqValid,
    input  logic           reqWrite,
    input  logic [25:0]    reqAddr,
    input  logic [127:0]   reqData,
    output logic           reqReady,
    output logic           rspValid,
    output logic [127:0]   rspData,
    output logic           rdTimeout
);

    reqState_t    state;
    logic         isWrite;
    logic [25:0]  lineAddr;
    logic [127:0] lineData;
    logic [1:0]   wcnt;
    logic         rspValidReg;
    logic         tokenSeen;
    logic         timeoutHit;
    logic [31:0]  wdWord;

    logic         asmLast;
    logic         asmDone;
    logic [127:0] asmLine;

    assign tokenSeen = (state == WAIT_TOKEN) && (SlotTypeIn == `Token);

    always_comb begin
        wdWord = lineData[31:0];
        case (wcnt)
            2'd1:    wdWord = lineData[63:32];
            2'd2:    wdWord = lineData[95:64];
            2'd3:    wdWord = lineData[127:96];
            default: wdWord = lineData[31:0];
        endcase
    end

    // Own slot only while holding the token; every other cycle is a straight wire.
    always_comb begin
        RingOut     = RingIn;
        SlotTypeOut = SlotTypeIn;
        SourceOut   = SourceIn;
        case (state)
            WAIT_TOKEN: begin
                if (SlotTypeIn == `Token) begin
                    RingOut     = addrWord(isWrite, lineAddr);
                    SlotTypeOut = `Address;
                    SourceOut   = MY_ID;
                end
            end
            SEND_WD: begin
                RingOut     = wdWord;
                SlotTypeOut = `WriteData;
                SourceOut   = MY_ID;
            end
            RELEASE: begin
                RingOut     = 32'd0;
                SlotTypeOut = `Token;
                SourceOut   = 4'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetB) begin
            state       <= IDLE;
            reqReady    <= 1'b0;
            rspValidReg <= 1'b0;
            wcnt        <= 2'd0;
            isWrite     <= 1'b0;
            lineAddr    <= '0;
            lineData    <= '0;
        end else begin
            rspValidReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        isWrite  <= reqWrite;
                        lineAddr <= reqAddr;
                        lineData <= reqData;
                        reqReady <= 1'b0;
                        state    <= WAIT_TOKEN;
                    end else begin
                        reqReady <= 1'b1;
                    end
                end
                WAIT_TOKEN: begin
                    if (tokenSeen) begin
                        wcnt  <= 2'd0;
                        state <= isWrite ? SEND_WD : RELEASE;
                    end
                end
                SEND_WD: begin
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (isWrite) begin
                        rspValidReg <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (timeoutHit) begin
                        rspValidReg <= 1'b1;
                        state       <= IDLE;
                    end else if (asmLast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ring_line_assembler #(
        .MY_ID (MY_ID)
    ) u_assembler (
        .clock    (clock),
        .resetB   (resetB),
        .clear    (timeoutHit),
        .enable   (state == WAIT_RD),
        .dest     (RDdest),
        .word     (RDreturn),
        .lastWord (asmLast),
        .done     (asmDone),
        .line     (asmLine)
    );

    assign rspValid = rspValidReg | asmDone;

`ifdef RD_TIMEOUT_EN
    localparam int TCW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    logic [TCW-1:0] rdCnt;
    logic           rdTimeoutReg;
    logic           rspOnes;

    assign timeoutHit = (state == WAIT_RD) && (rdCnt == TCW'(TIMEOUT - 1));

    // Counter idles at zero outside WAIT_RD, so it is already cleared on entry.
    always_ff @(posedge clock) begin
        if (!resetB) begin
            rdCnt        <= '0;
            rdTimeoutReg <= 1'b0;
            rspOnes      <= 1'b0;
        end else begin
            rdCnt <= (state == WAIT_RD) ? rdCnt + 1'b1 : '0;
            if (timeoutHit) begin
                rdTimeoutReg <= 1'b1;
                rspOnes      <= 1'b1;
            end else if (asmLast) begin
                rspOnes <= 1'b0;
            end
        end
    end

    assign rdTimeout = rdTimeoutReg;
    assign rspData   = rspOnes ? {128{1'b1}} : asmLine;
`else
    assign timeoutHit = 1'b0;
    assign rdTimeout  = 1'b0;
    assign rspData    = asmLine;
`endif

    always_ff @(posedge clock) begin
        if (resetB) begin
            assert (MY_ID != 4'd0 && TIMEOUT > 0)
                else $error("ring_mem_requester: MY_ID must be nonzero and TIMEOUT positive");
            if (state == SEND_WD || state == RELEASE) begin
                assert (SlotTypeIn == `Null || SlotTypeIn == `Token)
                    else $error("ring_mem_requester: foreign slot overwritten while holding token");
            end
            if (state != WAIT_RD) begin
                assert (RDdest != MY_ID)
                    else $error("ring_mem_requester: read word for this node outside WAIT_RD dropped");
            end
        end
    end

endmodule
